// File: rtl/writeback_buffer_p_pkg.sv
// Shared types and widths for the cache write-back path.
package cache_p_types;

    localparam int TAG_W    = 24;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [LINE_W-1:0]  data;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE,
        WB_BURST
    } wb_state_t;

    // Line-aligned memory address of a buffered victim.
    function automatic logic [ADDR_W-1:0] line_addr(input wb_entry_t e);
        return {e.tag, e.index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/writeback_buffer_p_fifo.sv
// Victim-line storage: circular buffer with per-entry valid bits.
module wb_fifo_p
    import cache_p_types::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PTR_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    // A full buffer never takes a push, so a valid entry is never overwritten.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign entries = mem;

    // Line payload storage; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_entry;
        end
    end

    // Pointers, occupancy and valid bits; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (do_push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_buffer_p.sv
// Write-back buffer: holds dirty victims, drains them to memory in
// four-beat bursts and answers miss lookups against buffered lines.
module writeback_buffer_p
    import cache_p_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                evict_valid_i,
    output logic                evict_ready_o,
    input  logic [TAG_W-1:0]    evict_tag_i,
    input  logic [INDEX_W-1:0]  evict_index_i,
    input  logic [LINE_W-1:0]   evict_data_i,
    input  logic [ADDR_W-1:0]   lookup_addr_i,
    output logic                lookup_hit_o,
    output logic [LINE_W-1:0]   lookup_data_o,
    output logic                pmem_write_o,
    output logic [ADDR_W-1:0]   pmem_address_o,
    output logic [BEAT_W-1:0]   pmem_wdata_o,
    input  logic                pmem_resp_i,
    output logic                empty_o,
    output logic                full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        push_entry;
    wb_entry_t        entries [DEPTH];
    wb_entry_t        head_entry;
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    wb_state_t        state;
    logic [1:0]       beat;
    logic             write_q;
    logic             unused_offset;

    assign push_entry    = '{tag: evict_tag_i, index: evict_index_i, data: evict_data_i};
    // Ready reflects occupancy at the start of the cycle, so a pop in the
    // same cycle cannot open room for a push.
    assign evict_ready_o = !fifo_full;
    assign push          = evict_valid_i && evict_ready_o;
    assign pop           = (state == WB_BURST) && pmem_resp_i && (beat == 2'(BEATS - 1));
    assign empty_o       = fifo_empty;
    assign full_o        = fifo_full;
    assign head_entry    = entries[head];
    assign unused_offset = ^lookup_addr_i[OFFSET_W-1:0];

    wb_fifo_p #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Burst sequencer: start whenever something is buffered, step a beat on
    // each memory response, and fall back to IDLE for a cycle after the last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= WB_IDLE;
            beat    <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    beat <= '0;
                    if (count != '0) begin
                        state   <= WB_BURST;
                        write_q <= 1'b1;
                    end
                end
                WB_BURST: begin
                    if (pmem_resp_i) begin
                        if (beat == 2'(BEATS - 1)) begin
                            state   <= WB_IDLE;
                            write_q <= 1'b0;
                            beat    <= '0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= WB_IDLE;
                    write_q <= 1'b0;
                    beat    <= '0;
                end
            endcase
        end
    end

    // Memory-side outputs: head line address and current beat, zero when idle.
    always_comb begin
        pmem_write_o   = write_q;
        pmem_address_o = '0;
        pmem_wdata_o   = '0;
        if (write_q) begin
            pmem_address_o = line_addr(head_entry);
            pmem_wdata_o   = head_entry.data[beat*BEAT_W +: BEAT_W];
        end
    end

    // Lookup walks oldest to newest from head so the newest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        idx           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] &&
                entries[idx].tag == lookup_addr_i[ADDR_W-1 -: TAG_W] &&
                entries[idx].index == lookup_addr_i[OFFSET_W +: INDEX_W]) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = entries[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer_p.sv
module tb_writeback_buffer_p;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         evict_valid_i = 1'b0;
    logic         evict_ready_o;
    logic [23:0]  evict_tag_i = '0;
    logic [2:0]   evict_index_i = '0;
    logic [255:0] evict_data_i = '0;
    logic [31:0]  lookup_addr_i = '0;
    logic         lookup_hit_o;
    logic [255:0] lookup_data_o;
    logic         pmem_write_o;
    logic [31:0]  pmem_address_o;
    logic [63:0]  pmem_wdata_o;
    logic         pmem_resp_i = 1'b0;
    logic         empty_o;
    logic         full_o;

    always #5 clk = ~clk;

    writeback_buffer_p #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .evict_valid_i  (evict_valid_i),
        .evict_ready_o  (evict_ready_o),
        .evict_tag_i    (evict_tag_i),
        .evict_index_i  (evict_index_i),
        .evict_data_i   (evict_data_i),
        .lookup_addr_i  (lookup_addr_i),
        .lookup_hit_o   (lookup_hit_o),
        .lookup_data_o  (lookup_data_o),
        .pmem_write_o   (pmem_write_o),
        .pmem_address_o (pmem_address_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_resp_i    (pmem_resp_i),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    typedef struct {
        logic [23:0]  tag;
        logic [2:0]   idx;
        logic [255:0] data;
    } line_t;

    line_t q[$];
    bit    m_burst = 1'b0;
    int    m_beat  = 0;
    bit    m_live  = 1'b0;
    int    checks  = 0;
    int    errors  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of lines plus "draining" flag and beat number.
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_burst = 1'b0;
            m_beat  = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            bit    do_push;
            bit    do_pop;
            line_t nl;
            do_push = evict_valid_i && (q.size() < DEPTH);
            do_pop  = m_burst && pmem_resp_i && (m_beat == 3);
            if (m_burst) begin
                if (pmem_resp_i) begin
                    if (m_beat == 3) begin
                        m_burst = 1'b0;
                        m_beat  = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end else if (q.size() != 0) begin
                m_burst = 1'b1;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                nl.tag  = evict_tag_i;
                nl.idx  = evict_index_i;
                nl.data = evict_data_i;
                q.push_back(nl);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            logic          e_hit;
            logic [255:0]  e_ld;
            logic [31:0]   e_addr;
            logic [63:0]   e_wd;
            e_hit  = 1'b0;
            e_ld   = '0;
            e_addr = '0;
            e_wd   = '0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].tag == lookup_addr_i[31:8] && q[i].idx == lookup_addr_i[7:5]) begin
                    e_hit = 1'b1;
                    e_ld  = q[i].data;
                end
            end
            if (m_burst) begin
                e_addr = {q[0].tag, q[0].idx, 5'b0};
                e_wd   = q[0].data[m_beat*64 +: 64];
            end
            check("m_full",   256'(full_o),        256'(q.size() == DEPTH));
            check("m_empty",  256'(empty_o),       256'(q.size() == 0));
            check("m_ready",  256'(evict_ready_o), 256'(q.size() < DEPTH));
            check("m_hit",    256'(lookup_hit_o),  256'(e_hit));
            check("m_ldata",  lookup_data_o,       e_ld);
            check("m_write",  256'(pmem_write_o),  256'(m_burst));
            check("m_addr",   256'(pmem_address_o), 256'(e_addr));
            check("m_wdata",  256'(pmem_wdata_o),  256'(e_wd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [23:0] tag, input logic [2:0] idx, input logic [255:0] data);
        evict_valid_i = 1'b1;
        evict_tag_i   = tag;
        evict_index_i = idx;
        evict_data_i  = data;
    endtask

    task automatic drain();
        int k;
        evict_valid_i = 1'b0;
        pmem_resp_i   = 1'b1;
        k = 0;
        while (!(empty_o === 1'b1 && pmem_write_o === 1'b0) && k < 60) begin
            step();
            k++;
        end
        check("drain_done", 256'(empty_o), 256'(1));
        pmem_resp_i = 1'b0;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int b = 0; b < 8; b++) d[b*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] la, lb, l2;
        logic [63:0]  d0, d1, d2, d3;
        bit           pat [7];
        int           k;

        rst = 1'b0;
        repeat (2) step();
        check("rst_ready", 256'(evict_ready_o), 256'(1));
        check("rst_empty", 256'(empty_o), 256'(1));
        check("rst_full", 256'(full_o), 256'(0));
        check("rst_hit", 256'(lookup_hit_o), 256'(0));
        check("rst_ldata", lookup_data_o, 256'(0));
        check("rst_write", 256'(pmem_write_o), 256'(0));
        check("rst_addr", 256'(pmem_address_o), 256'(0));
        check("rst_wdata", 256'(pmem_wdata_o), 256'(0));
        rst = 1'b1;
        step();

        // Single burst with response every cycle.
        d0 = 64'h0000_0000_D0D0_0000;
        d1 = 64'h1111_1111_D1D1_1111;
        d2 = 64'h2222_2222_D2D2_2222;
        d3 = 64'h3333_3333_D3D3_3333;
        offer(24'hABCDEF, 3'd5, {d3, d2, d1, d0});
        pmem_resp_i = 1'b1;
        step();
        evict_valid_i = 1'b0;
        step();
        check("b_write", 256'(pmem_write_o), 256'(1));
        check("b_addr", 256'(pmem_address_o), 256'(32'hABCDEFA0));
        check("b_beat0", 256'(pmem_wdata_o), 256'(d0));
        step();
        check("b_beat1", 256'(pmem_wdata_o), 256'(d1));
        step();
        check("b_beat2", 256'(pmem_wdata_o), 256'(d2));
        step();
        check("b_beat3", 256'(pmem_wdata_o), 256'(d3));
        step();
        check("b_empty", 256'(empty_o), 256'(1));
        check("b_idle", 256'(pmem_write_o), 256'(0));
        pmem_resp_i = 1'b0;

        // Fill with memory stalled, third line held back.
        offer(24'h000A01, 3'd1, rand_line());
        step();
        offer(24'h000A02, 3'd2, rand_line());
        step();
        check("f_full", 256'(full_o), 256'(1));
        check("f_ready", 256'(evict_ready_o), 256'(0));
        offer(24'h000A03, 3'd3, rand_line());
        step();
        check("f_held", 256'(evict_ready_o), 256'(0));
        pmem_resp_i = 1'b1;
        k = 0;
        while (evict_ready_o !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("f_ready_seen", 256'(evict_ready_o), 256'(1));
        step();
        evict_valid_i = 1'b0;
        check("f_third_in", 256'(full_o), 256'(1));
        drain();

        // Duplicate line lookup: newest wins.
        la = rand_line();
        lb = rand_line();
        offer(24'h000011, 3'd2, la);
        step();
        offer(24'h000011, 3'd2, lb);
        step();
        evict_valid_i = 1'b0;
        lookup_addr_i = 32'h0000_1140;
        #1;
        check("l_hit", 256'(lookup_hit_o), 256'(1));
        check("l_data", lookup_data_o, lb);
        lookup_addr_i = 32'h0000_1160;
        #1;
        check("l_miss", 256'(lookup_hit_o), 256'(0));
        check("l_miss_data", lookup_data_o, 256'(0));
        drain();

        // Responses with gaps.
        offer(24'h000B00, 3'd4, rand_line());
        step();
        evict_valid_i = 1'b0;
        step();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            pmem_resp_i = pat[i];
            check("g_write_held", 256'(pmem_write_o), 256'(1));
            check("g_not_popped", 256'(empty_o), 256'(0));
            step();
        end
        pmem_resp_i = 1'b0;
        check("g_popped", 256'(empty_o), 256'(1));
        check("g_idle", 256'(pmem_write_o), 256'(0));

        // Reset in the middle of a burst.
        offer(24'h000C00, 3'd6, rand_line());
        lookup_addr_i = 32'h000C00C0;
        step();
        evict_valid_i = 1'b0;
        step();
        pmem_resp_i = 1'b1;
        step();
        step();
        check("r_pre_hit", 256'(lookup_hit_o), 256'(1));
        pmem_resp_i = 1'b0;
        rst = 1'b0;
        step();
        check("r_write", 256'(pmem_write_o), 256'(0));
        check("r_empty", 256'(empty_o), 256'(1));
        check("r_ready", 256'(evict_ready_o), 256'(1));
        check("r_full", 256'(full_o), 256'(0));
        check("r_hit", 256'(lookup_hit_o), 256'(0));
        check("r_ldata", lookup_data_o, 256'(0));
        check("r_addr", 256'(pmem_address_o), 256'(0));
        check("r_wdata", 256'(pmem_wdata_o), 256'(0));
        rst = 1'b1;
        step();

        // Push and pop on the same edge, tail wrapping.
        offer(24'h000D01, 3'd1, rand_line());
        step();
        evict_valid_i = 1'b0;
        step();
        pmem_resp_i = 1'b1;
        step();
        step();
        step();
        l2 = rand_line();
        offer(24'h000D02, 3'd2, l2);
        step();
        evict_valid_i = 1'b0;
        pmem_resp_i   = 1'b0;
        check("pp_not_empty", 256'(empty_o), 256'(0));
        check("pp_not_full", 256'(full_o), 256'(0));
        step();
        check("pp_next_addr", 256'(pmem_address_o), 256'(32'h000D0240));
        offer(24'h000D03, 3'd3, rand_line());
        step();
        evict_valid_i = 1'b0;
        check("pp_full", 256'(full_o), 256'(1));
        drain();

        // Randomised traffic.
        for (int c = 0; c < 4000; c++) begin
            evict_valid_i = ($urandom_range(0, 1) == 1);
            evict_tag_i   = 24'h000100 + 24'($urandom_range(0, 2));
            evict_index_i = 3'($urandom_range(0, 1));
            evict_data_i  = rand_line();
            pmem_resp_i   = ($urandom_range(0, 2) != 0);
            lookup_addr_i = {24'h000100 + 24'($urandom_range(0, 2)),
                             3'($urandom_range(0, 1)), 5'($urandom_range(0, 31))};
            rst           = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
